// File: rtl/vm_pkg.sv
// Shared constants for the vending dispense stage: coin encodings, denominations,
// state encoding and request field widths.
package vm_pkg;

  localparam int ITEM_W = 3;
  localparam int AMT_W  = 2;
  localparam int CHG_W  = 6;
  localparam int DEN_W  = 4;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_10   = 3'b100;
  localparam logic [2:0] COIN_5    = 3'b010;
  localparam logic [2:0] COIN_1    = 3'b001;

  localparam logic [DEN_W-1:0] DEN_10 = 4'd10;
  localparam logic [DEN_W-1:0] DEN_5  = 4'd5;
  localparam logic [DEN_W-1:0] DEN_1  = 4'd1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_VEND  = 3'd1;
  localparam logic [2:0] ST_VWAIT = 3'd2;
  localparam logic [2:0] ST_CHG   = 3'd3;
  localparam logic [2:0] ST_CWAIT = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_VEND  = ST_VEND,
    S_VWAIT = ST_VWAIT,
    S_CHG   = ST_CHG,
    S_CWAIT = ST_CWAIT,
    S_FIN   = ST_FIN,
    S_ERR   = ST_ERR
  } state_t;

endpackage

// File: rtl/vm_coin_greedy.sv
// Picks the largest coin not exceeding the remaining change; nothing when the
// remainder is zero.
module vm_coin_greedy
  import vm_pkg::*;
(
  input  logic [CHG_W-1:0] rem,
  output logic [2:0]       sel,
  output logic [DEN_W-1:0] val
);

  always_comb begin
    sel = COIN_NONE;
    val = '0;
    if (rem >= CHG_W'(DEN_10)) begin
      sel = COIN_10;
      val = DEN_10;
    end else if (rem >= CHG_W'(DEN_5)) begin
      sel = COIN_5;
      val = DEN_5;
    end else if (rem != '0) begin
      sel = COIN_1;
      val = DEN_1;
    end
  end

endmodule

// File: rtl/vm_dispense_ctrl.sv
// Dispense controller: motor pulses per unit, then greedy coin change, each action
// acknowledged with a timeout. Optional counters enabled by VM_DISP_STATS_EN.
module vm_dispense_ctrl
  import vm_pkg::*;
#(
  parameter int PULSE_W     = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ITEM_W-1:0] req_item,
  input  logic [AMT_W-1:0]  req_amt,
  input  logic [CHG_W-1:0]  req_chg,
  output logic [ITEM_W-1:0] motor_sel,
  output logic              motor_pulse,
  input  logic              motor_done,
  output logic [2:0]        coin_eject,
  input  logic              coin_ack,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef VM_DISP_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_units,
  output logic [CNT_W-1:0]  stat_coins
`endif
);

  localparam int PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int TCW = $clog2(ACK_TIMEOUT);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_W - 1);
  localparam logic [TCW-1:0] TO_LAST    = TCW'(ACK_TIMEOUT - 1);

  if (PULSE_W < 1 || ACK_TIMEOUT < 2 || CNT_W < 1) begin : g_param_chk
    $error("vm_dispense_ctrl: parameter out of range");
  end

  state_t            state_reg, state_next;
  logic [ITEM_W-1:0] item_reg, item_next;
  logic [AMT_W-1:0]  amt_reg, amt_next;
  logic [CHG_W-1:0]  chg_reg, chg_next;
  logic [PCW-1:0]    pcnt_reg, pcnt_next;
  logic [TCW-1:0]    tcnt_reg, tcnt_next;

  logic [2:0]        coin_sel;
  logic [DEN_W-1:0]  coin_val;
  logic [AMT_W-1:0]  amt_dec;
  logic [CHG_W-1:0]  chg_dec;

  vm_coin_greedy u_greedy (
    .rem (chg_reg),
    .sel (coin_sel),
    .val (coin_val)
  );

  assign amt_dec = amt_reg - AMT_W'(1);
  assign chg_dec = chg_reg - CHG_W'(coin_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      item_reg  <= '0;
      amt_reg   <= '0;
      chg_reg   <= '0;
      pcnt_reg  <= '0;
      tcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      item_reg  <= item_next;
      amt_reg   <= amt_next;
      chg_reg   <= chg_next;
      pcnt_reg  <= pcnt_next;
      tcnt_reg  <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    item_next  = item_reg;
    amt_next   = amt_reg;
    chg_next   = chg_reg;
    pcnt_next  = pcnt_reg;
    tcnt_next  = tcnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          item_next = req_item;
          amt_next  = req_amt;
          chg_next  = req_chg;
          pcnt_next = '0;
          if (req_amt != '0)      state_next = S_VEND;
          else if (req_chg != '0) state_next = S_CHG;
          else                    state_next = S_FIN;
        end
      end
      S_VEND: begin
        if (pcnt_reg == PULSE_LAST) begin
          state_next = S_VWAIT;
          tcnt_next  = '0;
        end else begin
          pcnt_next = pcnt_reg + PCW'(1);
        end
      end
      // The ack is checked before the timeout so a late ack on the last cycle wins.
      S_VWAIT: begin
        if (motor_done) begin
          amt_next  = amt_dec;
          pcnt_next = '0;
          if (amt_dec != '0)      state_next = S_VEND;
          else if (chg_reg != '0) state_next = S_CHG;
          else                    state_next = S_FIN;
        end else if (tcnt_reg == TO_LAST) begin
          state_next = S_ERR;
        end else begin
          tcnt_next = tcnt_reg + TCW'(1);
        end
      end
      S_CHG: begin
        state_next = S_CWAIT;
        tcnt_next  = '0;
      end
      S_CWAIT: begin
        if (coin_ack) begin
          chg_next = chg_dec;
          if (chg_dec != '0) state_next = S_CHG;
          else               state_next = S_FIN;
        end else if (tcnt_reg == TO_LAST) begin
          state_next = S_ERR;
        end else begin
          tcnt_next = tcnt_reg + TCW'(1);
        end
      end
      S_FIN:   state_next = S_IDLE;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready   = (state_reg == S_IDLE);
  assign busy        = !req_ready;
  assign done        = (state_reg == S_FIN);
  assign err         = (state_reg == S_ERR);
  assign motor_pulse = (state_reg == S_VEND);
  assign coin_eject  = (state_reg == S_CHG) ? coin_sel : COIN_NONE;
  assign motor_sel   = busy ? item_reg : '0;

`ifdef VM_DISP_STATS_EN
  logic [1:0] stat_inc;
  assign stat_inc[0] = (state_reg == S_VWAIT) && motor_done;
  assign stat_inc[1] = (state_reg == S_CWAIT) && coin_ack;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst)                                cnt_reg <= '0;
      else if (stat_inc[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign stat_units = g_stat[0].cnt_reg;
  assign stat_coins = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// Bench for vm_dispense_ctrl: each sale is expanded into a per-cycle timeline of
// stimulus and expected outputs, then replayed and compared cycle by cycle.
module tb_vm_dispense_ctrl;

  localparam int PULSE_W     = 2;
  localparam int ACK_TIMEOUT = 16;
  localparam int CNT_W       = 16;
  localparam int NTAG        = 10;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, motor_pulse, motor_done, coin_ack;
  logic       busy, done, err;
  logic [2:0] req_item, motor_sel, coin_eject;
  logic [1:0] req_amt;
  logic [5:0] req_chg;
`ifdef VM_DISP_STATS_EN
  logic [CNT_W-1:0] stat_units, stat_coins;
`endif

  always #5 clk = ~clk;

  vm_dispense_ctrl #(.PULSE_W(PULSE_W), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_item(req_item), .req_amt(req_amt), .req_chg(req_chg),
    .motor_sel(motor_sel), .motor_pulse(motor_pulse), .motor_done(motor_done),
    .coin_eject(coin_eject), .coin_ack(coin_ack),
    .busy(busy), .done(done), .err(err)
`ifdef VM_DISP_STATS_EN
    , .stat_units(stat_units), .stat_coins(stat_coins)
`endif
  );

  typedef struct {
    bit         rst, rv, md, ca;
    logic [2:0] item;
    logic [1:0] amt;
    logic [5:0] chg;
    bit         chk;
    bit         ready, busy, done, err, pulse;
    logic [2:0] eject, sel;
    bit         uacc, cacc;
    int         tag;
  } cyc_t;

  cyc_t tl[$];
  int   cur_tag, sale_cyc, abort_at;
  bit   aborted;
  int   cur_idx;
  bit   cur_on;
  int   n_vec, n_err;
  int   pulse_cnt[NTAG], e10_cnt[NTAG], e5_cnt[NTAG], e1_cnt[NTAG], done_cnt[NTAG];
  int   exp_units, exp_coins;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s idx=%0d tag=%0d got=%0h want=%0h", nm, cur_idx, tl[cur_idx].tag, act, exp);
    end
  endtask

  task automatic lit(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic cyc_t idle_rec();
    cyc_t r = '{default: 0};
    r.chk = 1; r.ready = 1;
    return r;
  endfunction

  function automatic cyc_t busy_rec(logic [2:0] item);
    cyc_t r = '{default: 0};
    r.chk = 1; r.busy = 1; r.sel = item;
    return r;
  endfunction

  function automatic cyc_t junk(cyc_t r_in);
    cyc_t r = r_in;
    r.rv = 1; r.item = 3'd7; r.amt = 2'd3; r.chg = 6'd1;
    return r;
  endfunction

  task automatic add(cyc_t r_in);
    cyc_t r = r_in;
    if (aborted) return;
    r.tag = cur_tag;
    if (abort_at >= 0 && sale_cyc == abort_at) begin
      r.rst = 1; r.rv = 0; r.md = 0; r.ca = 0; r.chk = 0; r.uacc = 0; r.cacc = 0;
      aborted = 1;
    end
    tl.push_back(r);
    sale_cyc++;
  endtask

  task automatic push_idle(int n);
    for (int k = 0; k < n; k++) add(idle_rec());
  endtask

  task automatic push_rst(int n);
    cyc_t r = '{default: 0};
    r.rst = 1;
    for (int k = 0; k < n; k++) add(r);
  endtask

  // w = cycle of the wait on which the ack arrives (1 = first); 0 = never.
  task automatic wait_ack(logic [2:0] item, int w, bit is_coin, bit noise, output bit timed_out);
    cyc_t r;
    timed_out = (w == 0);
    for (int k = 0; k < ((w == 0) ? ACK_TIMEOUT : w); k++) begin
      r = busy_rec(item);
      if (noise) begin
        r = junk(r);
        if (is_coin) r.md = 1; else r.ca = 1;
      end
      if (w != 0 && k == w - 1) begin
        if (is_coin) begin r.ca = 1; r.cacc = 1; end
        else         begin r.md = 1; r.uacc = 1; end
      end
      add(r);
    end
  endtask

  task automatic sale(int tag, logic [2:0] item, int amt, int chg, int w, bit noise, int abort);
    cyc_t r;
    bit to;
    logic [2:0] coins[$];
    cur_tag = tag; sale_cyc = 0; aborted = 0; abort_at = abort;
    r = idle_rec(); r.rv = 1; r.item = item; r.amt = 2'(amt); r.chg = 6'(chg);
    add(r);
    for (int u = 0; u < amt; u++) begin
      for (int p = 0; p < PULSE_W; p++) begin
        r = busy_rec(item); r.pulse = 1;
        if (noise) begin r = junk(r); r.md = 1; r.ca = 1; end
        add(r);
      end
      wait_ack(item, w, 1'b0, noise, to);
      if (to) begin
        for (int k = 0; k < 4; k++) begin
          r = busy_rec(item); r.err = 1;
          r.rv = 1; r.amt = 0; r.chg = 0; r.md = 1; r.ca = 1;
          add(r);
        end
        push_rst(1);
        return;
      end
    end
    for (int k = 0; k < chg / 10; k++)       coins.push_back(3'b100);
    for (int k = 0; k < (chg % 10) / 5; k++) coins.push_back(3'b010);
    for (int k = 0; k < chg % 5; k++)        coins.push_back(3'b001);
    foreach (coins[c]) begin
      r = busy_rec(item); r.eject = coins[c];
      if (noise) begin r = junk(r); r.md = 1; r.ca = 1; end
      add(r);
      wait_ack(item, w, 1'b1, noise, to);
    end
    r = busy_rec(item); r.done = 1;
    add(r);
  endtask

  always @(negedge clk) begin
    cyc_t r;
    if (cur_on) begin
      r = tl[cur_idx];
      if (r.chk) begin
        n_vec++;
        chk("req_ready", 32'(req_ready), 32'(r.ready));
        chk("busy", 32'(busy), 32'(r.busy));
        chk("done", 32'(done), 32'(r.done));
        chk("err", 32'(err), 32'(r.err));
        chk("motor_pulse", 32'(motor_pulse), 32'(r.pulse));
        chk("coin_eject", 32'(coin_eject), 32'(r.eject));
        chk("motor_sel", 32'(motor_sel), 32'(r.sel));
`ifdef VM_DISP_STATS_EN
        chk("stat_units", 32'(stat_units), 32'(exp_units));
        chk("stat_coins", 32'(stat_coins), 32'(exp_coins));
`endif
        pulse_cnt[r.tag] += int'(motor_pulse);
        done_cnt[r.tag]  += int'(done);
        if (coin_eject == 3'b100) e10_cnt[r.tag]++;
        if (coin_eject == 3'b010) e5_cnt[r.tag]++;
        if (coin_eject == 3'b001) e1_cnt[r.tag]++;
      end
      if (r.rst) begin
        exp_units = 0; exp_coins = 0;
      end else begin
        exp_units += int'(r.uacc);
        exp_coins += int'(r.cacc);
      end
    end
  end

  initial begin
    rst = 1; req_valid = 0; req_item = 0; req_amt = 0; req_chg = 0;
    motor_done = 0; coin_ack = 0;
    cur_on = 0; cur_idx = 0; n_vec = 0; n_err = 0; exp_units = 0; exp_coins = 0;
    for (int t = 0; t < NTAG; t++) begin
      pulse_cnt[t] = 0; e10_cnt[t] = 0; e5_cnt[t] = 0; e1_cnt[t] = 0; done_cnt[t] = 0;
    end
    abort_at = -1; aborted = 0;

    cur_tag = 1; push_rst(3); push_idle(2);
    sale(2, 3'd2, 2, 0, 3, 1'b0, -1);            push_idle(2);
    sale(3, 3'd1, 1, 17, 1, 1'b0, -1);           push_idle(1);
    sale(4, 3'd5, 0, 0, 1, 1'b0, -1);            push_idle(1);
    sale(7, 3'd7, 3, 63, ACK_TIMEOUT, 1'b1, -1); push_idle(1);
    sale(8, 3'd4, 0, 9, 2, 1'b0, -1);            push_idle(1);
    sale(5, 3'd3, 1, 5, 0, 1'b1, -1);            push_idle(2);
    sale(6, 3'd6, 0, 63, 2, 1'b1, 5);            abort_at = -1; push_idle(3);

    foreach (tl[i]) begin
      @(posedge clk); #1;
      rst        = tl[i].rst;
      req_valid  = tl[i].rv;
      req_item   = tl[i].item;
      req_amt    = tl[i].amt;
      req_chg    = tl[i].chg;
      motor_done = tl[i].md;
      coin_ack   = tl[i].ca;
      cur_idx    = i;
      cur_on     = 1;
    end
    @(posedge clk); #1;
    cur_on = 0;

    lit("t2_pulse_cycles", pulse_cnt[2], 4);
    lit("t2_done", done_cnt[2], 1);
    lit("t2_coins", e10_cnt[2] + e5_cnt[2] + e1_cnt[2], 0);
    lit("t3_pulse_cycles", pulse_cnt[3], 2);
    lit("t3_e10", e10_cnt[3], 1);
    lit("t3_e5", e5_cnt[3], 1);
    lit("t3_e1", e1_cnt[3], 2);
    lit("t4_done", done_cnt[4], 1);
    lit("t4_activity", pulse_cnt[4] + e10_cnt[4] + e5_cnt[4] + e1_cnt[4], 0);
    lit("t7_pulse_cycles", pulse_cnt[7], 6);
    lit("t7_e10", e10_cnt[7], 6);
    lit("t7_e1", e1_cnt[7], 3);
    lit("t7_done", done_cnt[7], 1);
    lit("t8_e5", e5_cnt[8], 1);
    lit("t8_e1", e1_cnt[8], 4);
    lit("t5_done", done_cnt[5], 0);
    lit("t6_e10", e10_cnt[6], 2);
    lit("t6_done", done_cnt[6], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
